// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared definitions for the trace recorder. This covers the record
//            field codes, the number of compared fields, the reset value of
//            the last-value registers, the captured payload layout and the
//            output FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

  localparam int NUM_FIELDS = 5;

  localparam logic [31:0] LAST_RESET = 32'hFFFF_FFFF;

  localparam logic [2:0] FLD_PC    = 3'd0;
  localparam logic [2:0] FLD_INST  = 3'd1;
  localparam logic [2:0] FLD_ALU   = 3'd2;
  localparam logic [2:0] FLD_WDATA = 3'd3;
  localparam logic [2:0] FLD_RDATA = 3'd4;
  localparam logic [2:0] FLD_TS    = 3'd5;

  // The change mask and the five sampled values. The sequence number
  // (and the optional timestamp) are appended by the recorder, because
  // their widths depend on its configuration.
  typedef struct packed {
    logic [NUM_FIELDS-1:0]       mask;
    logic [NUM_FIELDS-1:0][31:0] fields;
  } trace_payload_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } trace_state_e;

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Purpose  : Synchronous FIFO with a combinational head. When the FIFO is full,
//            a push is accepted only if a pop happens in the same cycle.
// Ports    : clk, rst (sync, active-low)
//            push_i/wdata_i  - write side
//            pop_i/rdata_o   - read side (rdata_o is the current head)
//            full_o, empty_o, count_o - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign w_pop  = pop_i && !empty_o;
  // When full, the slot being written is the one being popped this cycle.
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : trace_fifo
`default_nettype wire

// File: rtl/trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : trace_recorder
// Purpose  : Change-driven CPU trace recorder. On each sampled cycle, the
//            recorder compares PC, instruction, ALU result, store data and
//            load data with their last values and queues the changed ones as
//            one entry. Each entry is then serialised as one 32-bit record per
//            changed field on a valid/ready stream.
// Ports    : clk, rst (sync, active-low)
//            sample_en, pc_in, inst_in, alu_res_in, dmem_wdata_in,
//            dmem_rdata_in                       - sampled CPU state
//            rec_valid/rec_ready, rec_field, rec_data, rec_seq - record stream
//            fifo_count, overflow_cnt, overflow_flag            - status
// Options  : TRACE_TIMESTAMP_EN - store a free-running cycle count in each
//            entry and emit it as a trailing field-5 record.
// Revision : 1.0 - initial release
// ============================================================================
module trace_recorder
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16,
  parameter int OVF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            inst_in,
  input  logic [31:0]            alu_res_in,
  input  logic [31:0]            dmem_wdata_in,
  input  logic [31:0]            dmem_rdata_in,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [2:0]             rec_field,
  output logic [31:0]            rec_data,
  output logic [SEQ_W-1:0]       rec_seq,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   overflow_flag
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int REM_W = NUM_FIELDS + 1;  // extra bit = timestamp pending
`else
  localparam int REM_W = NUM_FIELDS;
`endif

  typedef struct packed {
    trace_payload_t   payload;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]      ts;
`endif
    logic [SEQ_W-1:0] seq;
  } entry_t;

  logic [NUM_FIELDS-1:0][31:0] w_cur;
  logic [NUM_FIELDS-1:0][31:0] last_q;
  logic [NUM_FIELDS-1:0]       w_mask;
  logic                        w_cap;
  logic                        w_drop;
  logic [SEQ_W-1:0]            seq_q;
  logic [OVF_W-1:0]            ovf_cnt_q;
  logic                        ovf_flag_q;

  entry_t                      w_push_entry;
  entry_t                      w_head;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;

  trace_state_e                state_q, state_d;
  logic [REM_W-1:0]            rem_q, rem_d;
  logic [NUM_FIELDS-1:0][31:0] hold_fields_q, hold_fields_d;
  logic [SEQ_W-1:0]            hold_seq_q, hold_seq_d;
  logic                        w_last;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]                 ts_q;
  logic [31:0]                 hold_ts_q, hold_ts_d;
`endif

  // ---------------------------------------------------------------- capture
  always_comb begin
    w_cur            = '0;
    w_cur[FLD_PC]    = pc_in;
    w_cur[FLD_INST]  = inst_in;
    w_cur[FLD_ALU]   = alu_res_in;
    w_cur[FLD_WDATA] = dmem_wdata_in;
    w_cur[FLD_RDATA] = dmem_rdata_in;
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      w_mask[i] = (w_cur[i] != last_q[i]);
    end
  end

  assign w_cap  = sample_en && (w_mask != '0);
  // An entry is dropped only when the FIFO cannot take it this cycle.
  assign w_drop = w_cap && w_full && !w_pop;

  assign w_push_entry.payload.mask   = w_mask;
  assign w_push_entry.payload.fields = w_cur;
  assign w_push_entry.seq            = seq_q;
`ifdef TRACE_TIMESTAMP_EN
  assign w_push_entry.ts             = ts_q;
`endif

  trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_cap),
    .wdata_i (w_push_entry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count)
  );

  // ------------------------------------------------------------ output FSM
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    hold_fields_d = hold_fields_q;
    hold_seq_d    = hold_seq_q;
`ifdef TRACE_TIMESTAMP_EN
    hold_ts_d     = hold_ts_q;
`endif
    w_pop         = 1'b0;
    // The mask is never zero in EMIT, so "at most one bit" means "last record".
    w_last        = ((rem_q & (rem_q - REM_W'(1))) == '0);

    case (state_q)
      IDLE: begin
        if (!w_empty) w_pop = 1'b1;
      end
      EMIT: begin
        if (rec_ready) begin
          if (w_last) begin
            rem_d = '0;
            if (!w_empty) w_pop   = 1'b1;  // back-to-back entries, no bubble
            else          state_d = IDLE;
          end else begin
            rem_d = rem_q & (rem_q - REM_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_pop) begin
      state_d       = EMIT;
`ifdef TRACE_TIMESTAMP_EN
      rem_d         = {1'b1, w_head.payload.mask};
      hold_ts_d     = w_head.ts;
`else
      rem_d         = w_head.payload.mask;
`endif
      hold_fields_d = w_head.payload.fields;
      hold_seq_d    = w_head.seq;
    end
  end

  // Lowest pending bit selects the record, giving ascending field order.
  always_comb begin
    rec_field = '0;
    rec_data  = '0;
    if (state_q == EMIT) begin
`ifdef TRACE_TIMESTAMP_EN
      if (rem_q[NUM_FIELDS]) begin
        rec_field = FLD_TS;
        rec_data  = hold_ts_q;
      end
`endif
      for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
        if (rem_q[i]) begin
          rec_field = 3'(i);
          rec_data  = hold_fields_q[i];
        end
      end
    end
  end

  assign rec_valid     = (state_q == EMIT);
  assign rec_seq       = (state_q == EMIT) ? hold_seq_q : '0;
  assign overflow_cnt  = ovf_cnt_q;
  assign overflow_flag = ovf_flag_q;

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      hold_fields_q <= '0;
      hold_seq_q    <= '0;
      last_q        <= {NUM_FIELDS{LAST_RESET}};
      seq_q         <= '0;
      ovf_cnt_q     <= '0;
      ovf_flag_q    <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q          <= '0;
      hold_ts_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      hold_fields_q <= hold_fields_d;
      hold_seq_q    <= hold_seq_d;
      if (sample_en) last_q <= w_cur;
      // Dropped entries still consume a number so the consumer sees the gap.
      if (w_cap)     seq_q  <= seq_q + SEQ_W'(1);
      if (w_drop) begin
        ovf_flag_q <= 1'b1;
        if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + OVF_W'(1);
      end
`ifdef TRACE_TIMESTAMP_EN
      ts_q          <= ts_q + 32'd1;
      hold_ts_q     <= hold_ts_d;
`endif
    end
  end

endmodule : trace_recorder
`default_nettype wire

// File: tb/tb_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_recorder
// Purpose  : Self-checking bench for trace_recorder (DEPTH=4). It combines a
//            cycle-exact vector table for the basic flow, hand-written
//            overflow/stall/reset sequences and a randomized run. Expected
//            records come from a change-list model of the recorder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_recorder;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 16;
  localparam int OVF_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sample_en;
  logic [31:0]            pc_in, inst_in, alu_res_in, dmem_wdata_in, dmem_rdata_in;
  logic                   rec_valid;
  logic                   rec_ready;
  logic [2:0]             rec_field;
  logic [31:0]            rec_data;
  logic [SEQ_W-1:0]       rec_seq;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [OVF_W-1:0]       overflow_cnt;
  logic                   overflow_flag;

  trace_recorder #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .OVF_W(OVF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_en     (sample_en),
    .pc_in         (pc_in),
    .inst_in       (inst_in),
    .alu_res_in    (alu_res_in),
    .dmem_wdata_in (dmem_wdata_in),
    .dmem_rdata_in (dmem_rdata_in),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_field     (rec_field),
    .rec_data      (rec_data),
    .rec_seq       (rec_seq),
    .fifo_count    (fifo_count),
    .overflow_cnt  (overflow_cnt),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]       f;
    logic [31:0]      d;
    logic [SEQ_W-1:0] s;
  } rec_t;

  rec_t got[$];
  int   got_rd = 0;
  rec_t expq[$];

  // Reference model: last values, sequence number and dropped entries.
  logic [4:0][31:0] m_last;
  logic [SEQ_W-1:0] m_seq;
  int               m_drops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_last  = {5{32'hFFFF_FFFF}};
    m_seq   = '0;
    m_drops = 0;
    expq.delete();
    got_rd  = got.size();
  endfunction

  function automatic void model_sample(input logic [4:0][31:0] cur, input bit drop);
    rec_t r;
    bit   any = 1'b0;
    for (int i = 0; i < 5; i++) if (cur[i] != m_last[i]) any = 1'b1;
    if (any) begin
      if (drop) m_drops++;
      else begin
        for (int i = 0; i < 5; i++) begin
          if (cur[i] != m_last[i]) begin
            r.f = 3'(i); r.d = cur[i]; r.s = m_seq;
            expq.push_back(r);
          end
        end
      end
      m_seq = m_seq + 1'b1;
    end
    m_last = cur;
  endfunction

  // One clock: log accepted records, then check that stalled records held.
  task automatic step();
    bit               stall;
    logic [2:0]       pf;
    logic [31:0]      pd;
    logic [SEQ_W-1:0] ps;
    rec_t             r;
    stall = rst && rec_valid && !rec_ready;
    pf = rec_field; pd = rec_data; ps = rec_seq;
    if (rst && rec_valid && rec_ready) begin
      r.f = rec_field; r.d = rec_data; r.s = rec_seq;
      got.push_back(r);
    end
    @(posedge clk);
    #1;
    if (stall) begin
      chk("stall_valid", {31'd0, rec_valid}, 32'd1);
      chk("stall_field", {29'd0, rec_field}, {29'd0, pf});
      chk("stall_data", rec_data, pd);
      chk("stall_seq", {16'd0, rec_seq}, {16'd0, ps});
    end
  endtask

  task automatic drive(input bit se, input logic [4:0][31:0] cur, input bit rdy);
    sample_en     = se;
    pc_in         = cur[0];
    inst_in       = cur[1];
    alu_res_in    = cur[2];
    dmem_wdata_in = cur[3];
    dmem_rdata_in = cur[4];
    rec_ready     = rdy;
  endtask

  task automatic cyc(input bit se, input logic [4:0][31:0] cur, input bit rdy, input bit drop);
    drive(se, cur, rdy);
    if (se) model_sample(cur, drop);
    step();
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    sample_en = 1'b0;
    rec_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic drain_compare(input string name, input int budget);
    int n = 0;
    sample_en = 1'b0;
    rec_ready = 1'b1;
    while (n < budget &&
           !(rec_valid == 1'b0 && fifo_count == '0 && (got.size() - got_rd) >= expq.size())) begin
      step();
      n++;
    end
    if (n >= budget) chk({name, "_drain_timeout"}, 32'(n), 32'(budget - 1));
    chk({name, "_nrec"}, 32'(got.size() - got_rd), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (got_rd + i < got.size()) begin
        chk($sformatf("%s_rec%0d_field", name, i), {29'd0, got[got_rd+i].f}, {29'd0, expq[i].f});
        chk($sformatf("%s_rec%0d_data", name, i), got[got_rd+i].d, expq[i].d);
        chk($sformatf("%s_rec%0d_seq", name, i), {16'd0, got[got_rd+i].s}, {16'd0, expq[i].s});
      end
    end
    got_rd = got.size();
    expq.delete();
  endtask

  typedef struct {
    bit          se;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          rdy;
    bit          ev;
    logic [2:0]  ef;
    logic [31:0] ed;
    logic [15:0] es;
    logic [2:0]  ec;
  } vec_t;

  vec_t             vecs[16];
  logic [4:0][31:0] cur;

  initial begin
    // Cycle-exact table: first change record, idle hold, two-field entry.
    vecs[0] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd0, 32'h0, 16'd0, 3'd1};
    vecs[1] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd0, 32'h0, 16'd0, 3'd0};
    for (int i = 2; i < 12; i++)
      vecs[i] = '{1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd0, 32'h0, 16'd0, 3'd0};
    vecs[12] = '{1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b0, 3'd0, 32'h0, 16'd0, 3'd1};
    vecs[13] = '{1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b1, 3'd0, 32'h4, 16'd1, 3'd0};
    vecs[14] = '{1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b1, 3'd1, 32'h0050_0093, 16'd1, 3'd0};
    vecs[15] = '{1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b0, 3'd0, 32'h0, 16'd0, 3'd0};

    cur = {5{32'hFFFF_FFFF}};
    drive(1'b0, cur, 1'b0);
    do_reset();
    model_reset();

    chk("rst_valid", {31'd0, rec_valid}, 32'd0);
    chk("rst_field", {29'd0, rec_field}, 32'd0);
    chk("rst_data", rec_data, 32'd0);
    chk("rst_seq", {16'd0, rec_seq}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ovf_cnt", {16'd0, overflow_cnt}, 32'd0);
    chk("rst_ovf_flag", {31'd0, overflow_flag}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      cur    = {5{32'hFFFF_FFFF}};
      cur[0] = vecs[i].pc;
      cur[1] = vecs[i].inst;
      drive(vecs[i].se, cur, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, rec_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].ec});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_field", i), {29'd0, rec_field}, {29'd0, vecs[i].ef});
        chk($sformatf("vec%0d_data", i), rec_data, vecs[i].ed);
        chk($sformatf("vec%0d_seq", i), {16'd0, rec_seq}, {16'd0, vecs[i].es});
      end
    end

    // Overflow: six changing samples with the consumer stalled. Entry 0 moves
    // into the output holding register, entries 1..4 fill the FIFO, and entry
    // 5 is dropped but still consumes its sequence number.
    do_reset();
    model_reset();
    for (int k = 0; k < 6; k++) begin
      cur    = {5{32'hFFFF_FFFF}};
      cur[0] = 32'h100 + 32'(k);
      cyc(1'b1, cur, 1'b0, k >= 5);
    end
    chk("ovf_count", {29'd0, fifo_count}, 32'(DEPTH));
    chk("ovf_cnt", {16'd0, overflow_cnt}, 32'(m_drops));
    chk("ovf_flag", {31'd0, overflow_flag}, 32'd1);
    chk("ovf_head_valid", {31'd0, rec_valid}, 32'd1);
    chk("ovf_head_seq", {16'd0, rec_seq}, 32'd0);
    drain_compare("ovf_drain", 40);
    cur[0] = 32'h200;
    cyc(1'b1, cur, 1'b1, 1'b0);
    drain_compare("ovf_next", 20);
    chk("ovf_cnt_after", {16'd0, overflow_cnt}, 32'(m_drops));

    // Stalls during a three-field entry.
    do_reset();
    model_reset();
    cur    = {5{32'hFFFF_FFFF}};
    cur[0] = 32'h10; cur[1] = 32'h20; cur[2] = 32'h30;
    cyc(1'b1, cur, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) cyc(1'b0, cur, ($urandom % 3) == 0, 1'b0);
    drain_compare("stall", 20);

    // Reset in the middle of emitting an entry.
    cur    = {5{32'hFFFF_FFFF}};
    cur[0] = 32'h1; cur[1] = 32'h2; cur[2] = 32'h3;
    cyc(1'b1, cur, 1'b0, 1'b0);
    for (int k = 0; k < 5 && !rec_valid; k++) cyc(1'b0, cur, 1'b0, 1'b0);
    chk("midrst_pre_valid", {31'd0, rec_valid}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_valid", {31'd0, rec_valid}, 32'd0);
    chk("midrst_count", {29'd0, fifo_count}, 32'd0);
    model_reset();
    cur = {5{32'hFFFF_FFFF}};
    cur[0] = 32'h0;
    cyc(1'b1, cur, 1'b1, 1'b0);
    drain_compare("midrst_after", 20);

    // Randomized run, throttled so that the FIFO never overflows.
    do_reset();
    model_reset();
    cur = {5{32'hFFFF_FFFF}};
    for (int k = 0; k < 600; k++) begin
      bit se;
      for (int i = 0; i < 5; i++)
        if (($urandom % 3) == 0) cur[i] = ($urandom % 2) ? $urandom : 32'($urandom % 4);
      se = ($urandom % 2) == 1;
      if (fifo_count >= 3'(DEPTH - 1)) se = 1'b0;
      cyc(se, cur, ($urandom % 4) != 0, 1'b0);
    end
    drain_compare("rand", 200);
    chk("rand_ovf_cnt", {16'd0, overflow_cnt}, 32'(m_drops));
    chk("rand_ovf_flag", {31'd0, overflow_flag}, 32'(m_drops != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_trace_recorder
`default_nettype wire
